// File: rtl/store_buffer_if.sv
// Purpose     : core-side and memory-side bus bundle of the posted-write store buffer.
// Latency     : wires only; the buffer itself gives 1 cycle from push to mem_* presentation.
// Backpressure: stall goes back to the core; mem_ready comes back from memory.
//
// Signals
//   memwrite  [1:0]  core store size: 00 none, 01 word, 10 doubleword, 11 byte
//   dataadr   [AW]   core store/load address
//   writedata [DW]   core store data, right-justified for word/byte
//   memread          core load request at dataadr
//   stall            core holds its current request and inputs
//   fwd_valid        fwd_data carries the load result (forwarding build only)
//   fwd_data  [DW]   forwarded load data
//   mem_we    [1:0]  store size to memory, 00 = idle
//   mem_adr   [AW]   store address to memory
//   mem_wd    [DW]   store data to memory
//   mem_ready        memory accepts mem_* this cycle
//
// Modports
//   master : the environment, meaning the core plus the memory model
//   slave  : the store buffer
interface store_buffer_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic [1:0]    memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          memread;
    logic          stall;
    logic          fwd_valid;
    logic [DW-1:0] fwd_data;
    logic [1:0]    mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic          mem_ready;

    modport master (
        output memwrite, dataadr, writedata, memread, mem_ready,
        input  stall, fwd_valid, fwd_data, mem_we, mem_adr, mem_wd
    );

    modport slave (
        input  memwrite, dataadr, writedata, memread, mem_ready,
        output stall, fwd_valid, fwd_data, mem_we, mem_adr, mem_wd
    );
endinterface

// File: rtl/store_buffer.sv
// Purpose     : posted-write FIFO between the core data port and data memory. Stores are
//               drained in program order, and loads that hit a buffered store are checked.
// Latency     : a store pushed on edge N appears on mem_* after that edge. It pops on the
//               first later edge where mem_ready=1.
// Backpressure: stall is raised when the FIFO is full and a store is offered, or when a load
//               hits a buffered store that cannot be forwarded. stall never depends on mem_ready.
//
// Ports
//   clk    : clock; all state changes on the rising edge
//   reset  : asynchronous, active-low; clears all state immediately
//   sb     : store_buffer_if.slave, which carries the core request/stall/forward signals
//            and the memory mem_* / mem_ready signals
//   count  : number of occupied entries, clog2(DEPTH)+1 bits
//
// Build option: define STORE_BUFFER_FORWARD_EN to enable store-to-load forwarding. When the
// youngest matching entry is an exact-address doubleword, the load is forwarded. Any other
// match stalls the core. Without the macro, every load hazard stalls the core until the
// matching entries drain.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    store_buffer_if.slave           sb,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage: one size/address/data triple per slot, plus an occupancy flag.
    logic [1:0]    ent_size [DEPTH];
    logic [AW-1:0] ent_adr  [DEPTH];
    logic [DW-1:0] ent_dat  [DEPTH];
    logic [DEPTH-1:0] vld;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic push;
    logic pop;
    logic full;
    logic store_req;
    logic load_chk;
    logic hazard;
    logic fwd_ok;
    logic [PW-1:0] young_idx;
    logic [PW-1:0] scan_idx;

    assign store_req = (sb.memwrite != 2'b00);
    assign full      = (count == CW'(DEPTH));

    // A load in the same cycle as a store is illegal from the core. The store wins in that
    // case, and the load is not checked against the buffer.
    assign load_chk  = sb.memread && !store_req;

    // Scan the entries from oldest to youngest, starting at head. The last hit in the scan
    // is therefore the youngest matching store, which is the one a load must observe.
    // The match is a doubleword-aligned overlap, so address bits [2:0] are ignored.
    always_comb begin
        hazard    = 1'b0;
        young_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (vld[scan_idx] && (ent_adr[scan_idx][AW-1:3] == sb.dataadr[AW-1:3])) begin
                hazard    = 1'b1;
                young_idx = scan_idx;
            end
        end
    end

`ifdef STORE_BUFFER_FORWARD_EN
    // Only a full-width store at exactly the load address supplies every byte of the load.
    // A narrower store or an offset address leaves a byte mix, so those cases stall instead.
    assign fwd_ok = (ent_size[young_idx] == 2'b10) && (ent_adr[young_idx] == sb.dataadr);

    always_comb begin
        sb.fwd_valid = 1'b0;
        sb.fwd_data  = '0;
        if (load_chk && hazard && fwd_ok) begin
            sb.fwd_valid = 1'b1;
            sb.fwd_data  = ent_dat[young_idx];
        end
    end
`else
    assign fwd_ok       = 1'b0;
    assign sb.fwd_valid = 1'b0;
    assign sb.fwd_data  = '0;
`endif

    // The full term looks only at count. While the buffer is full, an offered store waits
    // one extra cycle even if memory drains an entry on this same edge. This keeps
    // mem_ready out of the stall timing path.
    assign sb.stall = (full && store_req) || (load_chk && hazard && !fwd_ok);

    assign push = store_req && !sb.stall;
    assign pop  = (count != '0) && sb.mem_ready;

    // The head entry is presented whenever the buffer is not empty. mem_ready is ignored
    // when the buffer is empty, because there is nothing to pop.
    always_comb begin
        sb.mem_we  = 2'b00;
        sb.mem_adr = '0;
        sb.mem_wd  = '0;
        if (count != '0) begin
            sb.mem_we  = ent_size[head];
            sb.mem_adr = ent_adr[head];
            sb.mem_wd  = ent_dat[head];
        end
    end

    // A push and a pop never target the same slot. Push needs count<DEPTH and pop needs
    // count>0. So head==tail with both active cannot happen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_size[i] <= 2'b00;
                ent_adr[i]  <= '0;
                ent_dat[i]  <= '0;
            end
        end else begin
            if (push) begin
                ent_size[tail] <= sb.memwrite;
                ent_adr[tail]  <= sb.dataadr;
                ent_dat[tail]  <= sb.writedata;
                vld[tail]      <= 1'b1;
                tail           <= tail + PW'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, single store, full/back-to-back drain,
// forwarding/hazard on loads, and reset while a drain is in progress.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    store_buffer_if #(.AW(AW), .DW(DW)) sb ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t log_q[$];

    // Memory-side monitor: the write that will be accepted on the coming rising edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && sb.mem_we !== 2'b00 && sb.mem_ready === 1'b1)
            log_q.push_back('{sb.mem_we, sb.mem_adr, sb.mem_wd});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb.memwrite  = 2'b00;
        sb.dataadr   = '0;
        sb.writedata = '0;
        sb.memread   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        sb.mem_ready = 1'b0;
        #1;
        total_cnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (sb.mem_we !== 2'b00) $display("FAIL reset_mem_we: got %b want 00", sb.mem_we); else pass_cnt++;
        total_cnt++; if (sb.mem_adr !== 64'd0) $display("FAIL reset_mem_adr: got %h want 0", sb.mem_adr); else pass_cnt++;
        total_cnt++; if (sb.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", sb.stall); else pass_cnt++;
        total_cnt++; if (sb.fwd_valid !== 1'b0 || sb.fwd_data !== 64'd0)
            $display("FAIL reset_fwd: got %b/%h want 0/0", sb.fwd_valid, sb.fwd_data); else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        wr_t exp;
        exp = '{2'b10, 64'd84, 64'd7};
        log_q.delete();
        sb.mem_ready = 1'b1;
        sb.memwrite = 2'b10; sb.dataadr = 64'd84; sb.writedata = 64'd7;
        tick();
        idle_inputs();
        total_cnt++; if (sb.mem_we !== 2'b10) $display("FAIL single_we: got %b want 10", sb.mem_we); else pass_cnt++;
        total_cnt++; if (sb.mem_adr !== 64'd84) $display("FAIL single_adr: got %0d want 84", sb.mem_adr); else pass_cnt++;
        total_cnt++; if (sb.mem_wd !== 64'd7) $display("FAIL single_wd: got %0d want 7", sb.mem_wd); else pass_cnt++;
        total_cnt++; if (count !== 3'd1) $display("FAIL single_count1: got %0d want 1", count); else pass_cnt++;
        tick();
        total_cnt++; if (count !== 3'd0) $display("FAIL single_count0: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (log_q.size() != 1 || log_q[0] !== exp)
            $display("FAIL single_mem_log: got %0d writes want 1 matching sd 7 @84", log_q.size()); else pass_cnt++;
        log_q.delete();
    endtask

    task automatic test_back_to_back();
        wr_t exp[5];
        exp[0] = '{2'b10, 64'h100, 64'h1111};
        exp[1] = '{2'b01, 64'h108, 64'h2222};
        exp[2] = '{2'b11, 64'h113, 64'h0033};
        exp[3] = '{2'b10, 64'h118, 64'h4444};
        exp[4] = '{2'b01, 64'h122, 64'h5555};
        log_q.delete();
        sb.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.memwrite = exp[i].we; sb.dataadr = exp[i].adr; sb.writedata = exp[i].wd;
            tick();
        end
        total_cnt++; if (count !== 3'd4) $display("FAIL b2b_full_count: got %0d want 4", count); else pass_cnt++;
        sb.memwrite = exp[4].we; sb.dataadr = exp[4].adr; sb.writedata = exp[4].wd;
        #1;
        total_cnt++; if (sb.stall !== 1'b1) $display("FAIL b2b_fifth_stall: got %b want 1", sb.stall); else pass_cnt++;
        tick();
        total_cnt++; if (count !== 3'd4) $display("FAIL b2b_held_count: got %0d want 4", count); else pass_cnt++;
        // Full with memory ready: stall must still be high this cycle.
        sb.mem_ready = 1'b1;
        #1;
        total_cnt++; if (sb.stall !== 1'b1) $display("FAIL full_ready_stall: got %b want 1", sb.stall); else pass_cnt++;
        tick();
        total_cnt++; if (sb.stall !== 1'b0 || count !== 3'd3)
            $display("FAIL full_next_accept: got stall=%b count=%0d want 0/3", sb.stall, count); else pass_cnt++;
        tick();
        idle_inputs();
        total_cnt++; if (count !== 3'd3) $display("FAIL push_pop_count: got %0d want 3", count); else pass_cnt++;
        for (int k = 0; k < 20 && count != 3'd0; k++) tick();
        total_cnt++; if (count !== 3'd0) $display("FAIL b2b_drain: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (log_q.size() != 5) $display("FAIL b2b_write_count: got %0d want 5", log_q.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (i >= log_q.size()) $display("FAIL b2b_order%0d: got missing write want adr %h", i, exp[i].adr);
            else if (log_q[i] !== exp[i])
                $display("FAIL b2b_order%0d: got %b/%h/%h want %b/%h/%h", i, log_q[i].we, log_q[i].adr,
                         log_q[i].wd, exp[i].we, exp[i].adr, exp[i].wd);
            else pass_cnt++;
        end
        log_q.delete();
    endtask

    task automatic test_forward();
        sb.mem_ready = 1'b0;
        sb.memwrite = 2'b10; sb.dataadr = 64'd80; sb.writedata = 64'd1;
        tick();
        idle_inputs();
        sb.memread = 1'b1; sb.dataadr = 64'd80;
        #1;
`ifdef STORE_BUFFER_FORWARD_EN
        total_cnt++; if (sb.fwd_valid !== 1'b1 || sb.fwd_data !== 64'd1 || sb.stall !== 1'b0)
            $display("FAIL fwd_hit: got v=%b d=%0d stall=%b want 1/1/0", sb.fwd_valid, sb.fwd_data, sb.stall); else pass_cnt++;
`else
        total_cnt++; if (sb.stall !== 1'b1 || sb.fwd_valid !== 1'b0)
            $display("FAIL load_hazard_stall: got stall=%b v=%b want 1/0", sb.stall, sb.fwd_valid); else pass_cnt++;
`endif
        // Add a younger store to the same address; the load must see it.
        tick();
        sb.memread = 1'b0;
        sb.memwrite = 2'b10; sb.dataadr = 64'd80; sb.writedata = 64'd2;
        tick();
        idle_inputs();
        sb.memread = 1'b1; sb.dataadr = 64'd80;
        #1;
`ifdef STORE_BUFFER_FORWARD_EN
        total_cnt++; if (sb.fwd_valid !== 1'b1 || sb.fwd_data !== 64'd2 || sb.stall !== 1'b0)
            $display("FAIL fwd_youngest: got v=%b d=%0d stall=%b want 1/2/0", sb.fwd_valid, sb.fwd_data, sb.stall); else pass_cnt++;
`else
        total_cnt++; if (sb.stall !== 1'b1) $display("FAIL load_hazard_two: got stall=%b want 1", sb.stall); else pass_cnt++;
`endif
        sb.mem_ready = 1'b1;
        for (int k = 0; k < 20 && count != 3'd0; k++) tick();
        total_cnt++; if (count !== 3'd0 || sb.stall !== 1'b0 || sb.fwd_valid !== 1'b0)
            $display("FAIL fwd_drained: got count=%0d stall=%b v=%b want 0/0/0", count, sb.stall, sb.fwd_valid); else pass_cnt++;
        idle_inputs();
        tick();
        log_q.delete();
    endtask

    task automatic test_partial_hazard();
        sb.mem_ready = 1'b0;
        sb.memwrite = 2'b01; sb.dataadr = 64'd84; sb.writedata = 64'h55;
        tick();
        idle_inputs();
        sb.memread = 1'b1; sb.dataadr = 64'd88;
        #1;
        total_cnt++; if (sb.stall !== 1'b0) $display("FAIL no_overlap_stall: got %b want 0", sb.stall); else pass_cnt++;
        sb.dataadr = 64'd80;
        #1;
        total_cnt++; if (sb.stall !== 1'b1 || sb.fwd_valid !== 1'b0)
            $display("FAIL sw_overlap_stall: got stall=%b v=%b want 1/0", sb.stall, sb.fwd_valid); else pass_cnt++;
        sb.mem_ready = 1'b1;
        #1;
        total_cnt++; if (sb.stall !== 1'b1) $display("FAIL sw_overlap_ready: got %b want 1", sb.stall); else pass_cnt++;
        tick();
        total_cnt++; if (count !== 3'd0 || sb.stall !== 1'b0)
            $display("FAIL sw_overlap_release: got count=%0d stall=%b want 0/0", count, sb.stall); else pass_cnt++;
        idle_inputs();
        tick();
        log_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        log_q.delete();
        sb.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.memwrite = 2'b10; sb.dataadr = 64'h200 + 64'(8 * i); sb.writedata = 64'(i + 9);
            tick();
        end
        idle_inputs();
        total_cnt++; if (count !== 3'd3 || sb.mem_we !== 2'b10)
            $display("FAIL pre_reset: got count=%0d we=%b want 3/10", count, sb.mem_we); else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++; if (count !== 3'd0 || sb.mem_we !== 2'b00)
            $display("FAIL async_reset: got count=%0d we=%b want 0/00", count, sb.mem_we); else pass_cnt++;
        tick();
        reset = 1'b1;
        sb.mem_ready = 1'b1;
        repeat (5) tick();
        total_cnt++; if (log_q.size() != 0 || count !== 3'd0)
            $display("FAIL post_reset_writes: got %0d writes count=%0d want 0/0", log_q.size(), count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_forward();
        test_partial_hazard();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
